// File: rtl/mul8_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul8_mac_pkg
// Brief    : Shared widths and the carry-aware saturating add for the MAC stage.
// Revision : 1.0
// ============================================================================
package mul8_mac_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;
    localparam int ACC_W_MAX = 64;

    // Sized for the widest supported accumulator; sat_add masks to the live width.
    typedef logic [ACC_W_MAX-1:0] acc_t;

    // Returns {carry, res}: carry is bit w of acc + prod, res is the w-bit result
    // (all-ones when sat is set and the add carried out).
    function automatic logic [ACC_W_MAX:0] sat_add(input acc_t acc,
                                                  input logic [15:0] prod,
                                                  input bit sat,
                                                  input int w);
        logic [ACC_W_MAX:0] sum;
        logic [ACC_W_MAX:0] cbit;
        acc_t               mask;
        logic               carry;
        sum   = {1'b0, acc} + {{(ACC_W_MAX-15){1'b0}}, prod};
        cbit  = {{ACC_W_MAX{1'b0}}, 1'b1} << w;
        carry = |(sum & cbit);
        mask  = ~({ACC_W_MAX{1'b1}} << w);
        if (sat && carry) begin
            return {carry, mask};
        end
        return {carry, sum[ACC_W_MAX-1:0] & mask};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul8_mac_accum_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : mul8_mac_out_reg
// Brief    : One-deep valid/ready result holding register; a load beats a drain.
// Revision : 1.0
// ============================================================================
module mul8_mac_out_reg #(
    parameter int DATA_W = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_ovf,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_ovf
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (i_load) begin
            valid_d = 1'b1;
            data_d  = i_data;
            count_d = i_count;
            ovf_d   = i_ovf;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_count = count_q;
    assign o_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/mul8_mac_accum.sv
`default_nettype none
// ============================================================================
// Module   : mul8_mac_accum
// Brief    : Streaming MAC stage summing an external 8x8 multiplier's products per frame.
// Revision : 1.0
// ============================================================================
module mul8_mac_accum
    import mul8_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    if (ACC_W < 16 || ACC_W >= ACC_W_MAX) begin : g_acc_w_check
        $error("mul8_mac_accum: ACC_W must be in [16, %0d)", ACC_W_MAX);
    end

    logic             s1_v_q, s1_v_d;
    logic             s1_last_q, s1_last_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q;

    logic                          stall;
    logic                          accept;
    logic                          load;
    logic [ACC_W_MAX:0]            add_r;
    logic                          carry;
    logic [ACC_W-1:0]              res;
    logic [ACC_W_MAX-ACC_W-1:0]    unused_add_hi;
    logic                          cnt_full;
    logic [CNT_W-1:0]              cnt_n;
    logic                          ovf_n;

    // Only a finished frame waiting behind an unaccepted result can block the pipe.
    assign stall    = s1_v_q & s1_last_q & out_valid & ~out_ready;
    assign in_ready = rdy_q & ~stall;
    assign accept   = in_valid & in_ready;
    assign load     = s1_v_q & s1_last_q & ~stall & ~flush;

    assign add_r         = sat_add({{(ACC_W_MAX-ACC_W){1'b0}}, acc_q}, mul_o, SAT, ACC_W);
    assign carry         = add_r[ACC_W_MAX];
    assign res           = add_r[ACC_W-1:0];
    assign unused_add_hi = add_r[ACC_W_MAX-1:ACC_W];

    assign cnt_full = &cnt_q;
    assign cnt_n    = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_n    = ovf_q | carry | cnt_full;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_last_d = s1_last_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        if (flush) begin
            s1_v_d = 1'b0;
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
        end else if (!stall) begin
            s1_v_d = accept;
            if (accept) begin
                mul_a_d   = in_a;
                mul_b_d   = in_b;
                s1_last_d = in_last;
            end
            if (s1_v_q) begin
                if (s1_last_q) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = res;
                    cnt_d = cnt_n;
                    ovf_d = ovf_n;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rdy_q     <= 1'b1;
        end
    end

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

    mul8_mac_out_reg #(
        .DATA_W (ACC_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (load),
        .i_data  (res),
        .i_count (cnt_n),
        .i_ovf   (ovf_n),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_count (out_count),
        .o_ovf   (out_ovf)
    );

endmodule
`default_nettype wire
